// File: rtl/bch_dec_stream_if.sv
// Stream bundle for the serial BCH decoder: accepted channel bits in,
// corrected data bits and per-codeword status out.
interface bch_dec_stream_if;
  logic       din_valid;
  logic       din;
  logic       dout_valid;
  logic       dout;
  logic       dout_first;
  logic       status_valid;
  logic [1:0] err_count;
  logic       uncorrectable;

  modport master (
    output din_valid, din,
    input  dout_valid, dout, dout_first, status_valid, err_count, uncorrectable
  );

  modport slave (
    input  din_valid, din,
    output dout_valid, dout, dout_first, status_valid, err_count, uncorrectable
  );
endinterface

// File: rtl/bch_dec_stream.sv
// Serial BCH (T=1/2) decoder: syndromes of codeword j+1 accumulate while a
// bit-serial Chien search corrects codeword j out of an N-bit delay line.
module bch_dec_stream #(
  parameter int N = 15,
  parameter int K = 7,
  parameter int T = 2
) (
  input logic             clk,
  input logic             reset,
  bch_dec_stream_if.slave bus
);

  function automatic int n2m(input int n);
    for (int m = 2; m <= 16; m++)
      if (((1 << m) - 1) >= n) return m;
    return 16;
  endfunction

  // Primitive polynomials with the x^M term dropped.
  function automatic logic [15:0] prim_low(input int m);
    case (m)
      3:       return 16'h0003;
      4:       return 16'h0003;
      5:       return 16'h0005;
      6:       return 16'h0003;
      7:       return 16'h0009;
      8:       return 16'h001D;
      9:       return 16'h0011;
      10:      return 16'h0009;
      default: return 16'h0003;
    endcase
  endfunction

  localparam int M  = n2m(N);
  localparam int PW = $clog2(N);

  typedef logic [M-1:0] gf_t;

  localparam gf_t POLY  = gf_t'(prim_low(M));
  localparam gf_t ALPHA = gf_t'(2);

  function automatic gf_t gf_mul(input gf_t a, input gf_t b);
    gf_t acc;
    acc = '0;
    for (int i = M - 1; i >= 0; i--) begin
      acc = acc[M-1] ? ((acc << 1) ^ POLY) : (acc << 1);
      if (b[i]) acc = acc ^ a;
    end
    return acc;
  endfunction

  function automatic gf_t alpha_pow(input int e);
    gf_t x;
    x = gf_t'(1);
    for (int i = 0; i < e; i++) x = gf_mul(x, ALPHA);
    return x;
  endfunction

  localparam gf_t ALPHA3    = alpha_pow(3);
  localparam gf_t ALPHA_INV = alpha_pow(N - 1);

  if ((T != 1) && (T != 2)) begin : g_bad_t
    $error("bch_dec_stream: T must be 1 or 2");
  end
  if ((N != ((1 << M) - 1)) || (K >= N) || (K < 1)) begin : g_bad_nk
    $error("bch_dec_stream: N must be 2^M-1 and 0 < K < N");
  end

  logic [PW-1:0] p_q, p_d;
  gf_t           s1_q, s1_d, s3_q, s3_d;
  gf_t           x_q, x_d;
  gf_t           a2_q, a2_d, a1_q, a1_d, a0_q, a0_d;
  logic [N-1:0]  dly_q, dly_d;
  logic          pending_q, pending_d;
  logic          srch_q, srch_d;
  logic          unc_q, unc_d;
  logic [1:0]    deg_q, deg_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          dout_valid_q, dout_valid_d;
  logic          dout_q, dout_d;
  logic          first_q, first_d;
  logic          stat_q, stat_d;
  logic [1:0]    err_count_q, err_count_d;
  logic          uncorr_q, uncorr_d;

  gf_t        s1_acc, s3_acc, s1_cube, loc_eval;
  logic       last_bit, is_root;
  logic [1:0] cnt_inc;

  always_comb begin
    // NOTE: every next-state signal is given its hold value before any branch, so no path can infer a latch.
    p_d          = p_q;
    s1_d         = s1_q;
    s3_d         = s3_q;
    x_d          = x_q;
    a2_d         = a2_q;
    a1_d         = a1_q;
    a0_d         = a0_q;
    dly_d        = dly_q;
    pending_d    = pending_q;
    srch_d       = srch_q;
    unc_d        = unc_q;
    deg_d        = deg_q;
    cnt_d        = cnt_q;
    dout_valid_d = 1'b0;
    dout_d       = dout_q;
    first_d      = 1'b0;
    stat_d       = 1'b0;
    err_count_d  = err_count_q;
    uncorr_d     = uncorr_q;

    last_bit = (p_q == PW'(N - 1));
    s1_acc   = gf_mul(s1_q, ALPHA) ^ gf_t'(bus.din);
    s3_acc   = gf_mul(s3_q, ALPHA3) ^ gf_t'(bus.din);
    s1_cube  = gf_mul(s1_acc, gf_mul(s1_acc, s1_acc));

    // Locator scaled by S1 so no field inverse is needed: S1*X^2 + S1^2*X + (S3 + S1^3).
    loc_eval = gf_mul(a2_q, gf_mul(x_q, x_q)) ^ gf_mul(a1_q, x_q) ^ a0_q;
    is_root  = pending_q && srch_q && (loc_eval == '0);
    cnt_inc  = cnt_q + {1'b0, is_root};

    if (bus.din_valid) begin
      p_d   = last_bit ? '0 : p_q + 1'b1;
      x_d   = gf_mul(x_q, ALPHA_INV);
      dly_d = {dly_q[N-2:0], bus.din};
      s1_d  = s1_acc;
      s3_d  = s3_acc;
      cnt_d = cnt_inc;

      if (pending_q && (p_q < PW'(K))) begin
        dout_valid_d = 1'b1;
        dout_d       = dly_q[N-1] ^ is_root;
        first_d      = (p_q == '0);
      end

      if (pending_q && last_bit) begin
        stat_d      = 1'b1;
        err_count_d = cnt_inc;
        uncorr_d    = unc_q || (cnt_inc != deg_q);
      end

      if (last_bit) begin
        s1_d      = '0;
        s3_d      = '0;
        cnt_d     = '0;
        pending_d = 1'b1;
        srch_d    = (s1_acc != '0);
        if (T == 1) begin
          a2_d  = '0;
          a1_d  = gf_t'(1);
          a0_d  = s1_acc;
          deg_d = {1'b0, srch_d};
          unc_d = 1'b0;
        end else begin
          a2_d  = s1_acc;
          a1_d  = gf_mul(s1_acc, s1_acc);
          a0_d  = s3_acc ^ s1_cube;
          deg_d = (s1_acc == '0) ? 2'd0 : ((s3_acc == s1_cube) ? 2'd1 : 2'd2);
          unc_d = (s1_acc == '0) && (s3_acc != '0);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p_q          <= '0;
      s1_q         <= '0;
      s3_q         <= '0;
      x_q          <= ALPHA_INV;
      a2_q         <= '0;
      a1_q         <= '0;
      a0_q         <= '0;
      // NOTE: the delay line is a plain register chain, so it takes the reset like every other state bit.
      dly_q        <= '0;
      pending_q    <= 1'b0;
      srch_q       <= 1'b0;
      unc_q        <= 1'b0;
      deg_q        <= '0;
      cnt_q        <= '0;
      dout_valid_q <= 1'b0;
      dout_q       <= 1'b0;
      first_q      <= 1'b0;
      stat_q       <= 1'b0;
      err_count_q  <= '0;
      uncorr_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      p_q          <= p_d;
      s1_q         <= s1_d;
      s3_q         <= s3_d;
      x_q          <= x_d;
      a2_q         <= a2_d;
      a1_q         <= a1_d;
      a0_q         <= a0_d;
      dly_q        <= dly_d;
      pending_q    <= pending_d;
      srch_q       <= srch_d;
      unc_q        <= unc_d;
      deg_q        <= deg_d;
      cnt_q        <= cnt_d;
      dout_valid_q <= dout_valid_d;
      dout_q       <= dout_d;
      first_q      <= first_d;
      stat_q       <= stat_d;
      err_count_q  <= err_count_d;
      uncorr_q     <= uncorr_d;
    end
  end

  assign bus.dout_valid    = dout_valid_q;
  assign bus.dout          = dout_q;
  assign bus.dout_first    = first_q;
  assign bus.status_valid  = stat_q;
  assign bus.err_count     = err_count_q;
  assign bus.uncorrectable = uncorr_q;

endmodule

// File: doc/bch_dec_stream.md
Name: bch_dec_stream

Overview:
- Serial binary BCH decoder for T of 1 or 2 with a valid-gated input stream; processes back-to-back codewords continuously.
- Emits corrected systematic data bits for codeword j while codeword j+1 is being received.
- Per-codeword status: corrected-error count and uncorrectable flag.
- Sits between the channel bit deserialiser and the data sink; built from the team's existing GF(2^M) syndrome, Chien-step, cube and counter helpers.

Parameters:
- N, 15, codeword length; N = 2^M - 1.
- K, 7, data bits per codeword; data is sent first, parity last.
- T, 2, correctable errors; only 1 or 2 legal, else elaboration error.
- M (localparam), n2m(N), field degree; primitive polynomial from the team's bch tables (M=4: x^4+x+1).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- din_valid  in  1  din is accepted this cycle.
- din  in  1  received bit.
- dout_valid  out  1  dout carries a corrected data bit.
- dout  out  1  corrected data bit.
- dout_first  out  1  marks the first data bit of a codeword; qualified by dout_valid.
- status_valid  out  1  one-cycle strobe; err_count and uncorrectable are valid.
- err_count  out  2  number of error locations found (0..T).
- uncorrectable  out  1  decoder failure detected.

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs go to 0.
  - Bit counter p goes to 0, the pending-codeword flag is cleared, and syndromes and the delay buffer are cleared.
  - Any partial codeword is discarded.
- Input acceptance:
  - A bit is accepted only on a clk edge with din_valid=1 and reset=1.
  - p counts 0..N-1 and wraps to 0 after N-1. There is no dead cycle between codewords.
  - With din_valid=0, all state freezes, dout_valid=0 and status_valid=0 next cycle, and dout holds its value.
- Bit order: accepted bit p is coefficient r_(N-1-p) of r(x).
- Syndromes: S1 = r(α), S3 = r(α^3); S3 is used only when T=2. Both are latched into the correction stage when p=N-1 is accepted.
- Error locations for T=1:
  - S1=0: no error.
  - Otherwise a single error at i where α^i = S1.
- Error locations for T=2:
  - S1=0 and S3=0: no error.
  - S1≠0 and S3=S1^3: single error at α^i = S1.
  - S1≠0 and S3≠S1^3: errors at the roots X=α^i of X^2 + S1·X + (S3+S1^3)/S1.
  - S1=0 and S3≠0: uncorrectable, no corrections applied.
- Output stream:
  - Corrected output of codeword j is produced while codeword j+1 is accepted.
  - On the accept of codeword j+1 bit p (p<K), the next cycle gives dout_valid=1 and dout = r_(N-1-p) XOR e_(N-1-p) of codeword j.
  - dout_first=1 when p=0.
  - Accepts with p≥K produce dout_valid=0.
  - Latency is exactly N accepted bits plus 1 clk.
- Chien search:
  - Evaluates all N positions, one per accepted bit of codeword j+1, including parity positions.
  - Roots are counted as the search runs.
- Status:
  - The cycle after the accept of codeword j+1 bit N-1 gives status_valid=1.
  - err_count = number of roots found.
  - uncorrectable=1 if S1=0 and S3≠0, or if the root count differs from the locator degree (1 or 2).
  - When uncorrectable, data bits are still emitted with whatever flips were applied. err_count still reports the root count.
- First codeword after reset: produces no dout_valid and no status. Output starts with the second codeword.
- Draining: the last real codeword is only output after another N accepts. The sink feeds a dummy all-zero codeword.
- Reset mid-stream:
  - Outputs of the pending codeword are aborted.
  - A status strobe is not emitted for the aborted codeword.
- Sequencing at the codeword boundary: the accept at p=N-1 both closes codeword j+1 syndromes and ends codeword j's search. Status for j and the syndrome hand-off for j+1 occur on the same edge without loss.

Test Plan (N=15, K=7, T=2):
- Clean stream: all-zero codeword ×3, din_valid=1 throughout → 14 dout_valid pulses, all dout=0. Two status strobes, each with err_count=0 and uncorrectable=0.
- Single error: invert bit p=0 (r_14) of codeword 1, then send a dummy → first dout of codeword 1 = 0. Status err_count=1, uncorrectable=0.
- Two errors: invert r_14 and r_3 of a zero codeword → all 7 data bits = 0. err_count=2; the parity-position correction is counted but not emitted.
- Uncorrectable: invert r_0, r_1 and r_4 (S1=0, S3=α^2+α) → data bits all 0 and unchanged. err_count=0, uncorrectable=1.
- Gapped valid: the non-zero valid codeword (data 1011001) is fed with a random 50% din_valid and one error at r_10 → dout sequence 1011001. dout_valid only on the cycle after an accept, and dout holds during gaps.
- Reset mid-codeword: assert reset at p=6 of codeword 2 → outputs go to 0 immediately. The next codeword after release produces no output, and the one after it decodes normally.
